// File: rtl/rr_arbiter_4_if.sv
// Request/grant bundle for the four-way round-robin arbiter.
// master = requester side, slave = arbiter side.
interface rr_arbiter_4_if;
   logic [3:0] req;
   logic       done;
   logic [3:0] gnt;
   logic [1:0] gnt_idx;
   logic       busy;
   logic       timeout;

   modport master (
      output req,
      output done,
      input  gnt,
      input  gnt_idx,
      input  busy,
      input  timeout
   );

   modport slave (
      input  req,
      input  done,
      output gnt,
      output gnt_idx,
      output busy,
      output timeout
   );
endinterface

// File: rtl/rr_arbiter_4.sv
// Four-requester round-robin arbiter with a bounded grant tenure.
// IDLE arbitrates, GRANT holds the owner, RELEASE inserts one dead cycle.
module rr_arbiter_4 #(
   parameter int MAX_HOLD = 15,
   parameter int HOLD_W   = 4
) (
   input  logic           clk,
   input  logic           rst,
   rr_arbiter_4_if.slave  bus
);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      GRANT   = 2'd1,
      RELEASE = 2'd2
   } state_t;

   state_t            state_reg;
   logic [HOLD_W-1:0] hold_cnt_reg;
   logic [3:0]        gnt_reg;
   logic [1:0]        gnt_idx_reg;
   logic              busy_reg;
   logic              timeout_reg;

   logic [1:0]        winner;
   logic [3:0]        winner_onehot;
   logic              owner_req;
   logic              expire;
   logic              release_now;

   // gnt_idx_reg doubles as the round-robin pointer: it keeps the last owner
   // after release, so the search starts just past it.
   always_comb begin
      logic [1:0] idx;
      logic       found;
      winner = gnt_idx_reg;
      idx    = gnt_idx_reg;
      found  = 1'b0;
      for (int k = 1; k <= 4; k++) begin
         idx = gnt_idx_reg + 2'(k);
         if (!found && bus.req[idx]) begin
            winner = idx;
            found  = 1'b1;
         end
      end
   end

   genvar gi;
   generate
      for (gi = 0; gi < 4; gi++) begin : g_dec
         assign winner_onehot[gi] = (winner == 2'(gi));
      end
   endgenerate

   assign owner_req   = bus.req[gnt_idx_reg];
   assign expire      = (hold_cnt_reg == HOLD_W'(MAX_HOLD - 1));
   assign release_now = bus.done || !owner_req || expire;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg    <= IDLE;
         hold_cnt_reg <= '0;
         gnt_reg      <= 4'b0000;
         gnt_idx_reg  <= 2'd3;
         busy_reg     <= 1'b0;
         timeout_reg  <= 1'b0;
      end else begin
         timeout_reg <= 1'b0;
         case (state_reg)
            IDLE: begin
               if (|bus.req) begin
                  state_reg    <= GRANT;
                  gnt_idx_reg  <= winner;
                  gnt_reg      <= winner_onehot;
                  busy_reg     <= 1'b1;
                  hold_cnt_reg <= '0;
               end
            end
            GRANT: begin
               if (release_now) begin
                  state_reg   <= RELEASE;
                  gnt_reg     <= 4'b0000;
                  busy_reg    <= 1'b0;
                  // Flag expiry only when it alone ended the tenure.
                  timeout_reg <= expire && !bus.done && owner_req;
               end else begin
                  hold_cnt_reg <= hold_cnt_reg + 1'b1;
               end
            end
            RELEASE: state_reg <= IDLE;
            default: state_reg <= IDLE;
         endcase
      end
   end

   assign bus.gnt     = gnt_reg;
   assign bus.gnt_idx = gnt_idx_reg;
   assign bus.busy    = busy_reg;
   assign bus.timeout = timeout_reg;

endmodule

// File: tb/tb_rr_arbiter_4.sv
// Randomized and directed bench for rr_arbiter_4 against a tenure-level
// reference model (owner, cycles held, dead cycles remaining).
module tb_rr_arbiter_4;
   localparam int MAX_HOLD = 4;
   localparam int HOLD_W   = 4;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   rr_arbiter_4_if bus_if ();

   rr_arbiter_4 #(.MAX_HOLD(MAX_HOLD), .HOLD_W(HOLD_W)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus_if)
   );

   int n_checks = 0;
   int n_fail   = 0;

   // Reference model: owner = -1 when nobody holds the resource.
   int m_owner;
   int m_last;
   int m_tenure;
   int m_dead;
   bit m_to;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic m_reset();
      m_owner  = -1;
      m_last   = 3;
      m_tenure = 0;
      m_dead   = 0;
      m_to     = 1'b0;
   endtask

   task automatic model_edge();
      bit d, dr, ex;
      m_to = 1'b0;
      if (m_owner >= 0) begin
         d  = bus_if.done;
         dr = !bus_if.req[m_owner];
         ex = (m_tenure == MAX_HOLD);
         if (d || dr || ex) begin
            m_last  = m_owner;
            m_owner = -1;
            m_dead  = 1;
            m_to    = ex && !d && !dr;
         end else begin
            m_tenure++;
         end
      end else if (m_dead > 0) begin
         m_dead--;
      end else if (bus_if.req != 4'b0000) begin
         for (int k = 1; k <= 4; k++) begin
            if (m_owner < 0 && bus_if.req[(m_last + k) % 4]) m_owner = (m_last + k) % 4;
         end
         m_tenure = 1;
      end
   endtask

   task automatic check_all(input string tag);
      logic [3:0] eg;
      eg = (m_owner >= 0) ? 4'(1 << m_owner) : 4'b0000;
      chk({tag, ".gnt"}, 32'(bus_if.gnt), 32'(eg));
      chk({tag, ".idx"}, 32'(bus_if.gnt_idx), (m_owner >= 0) ? m_owner : m_last);
      chk({tag, ".busy"}, 32'(bus_if.busy), 32'(m_owner >= 0));
      chk({tag, ".timeout"}, 32'(bus_if.timeout), 32'(m_to));
      chk({tag, ".onehot"}, 32'($countones(bus_if.gnt) <= 1), 32'd1);
   endtask

   task automatic step(input string tag);
      @(posedge clk);
      model_edge();
      @(negedge clk);
      check_all(tag);
   endtask

   // Asserts rst between edges, checks the immediate effect, releases it.
   task automatic pulse_reset(input string tag);
      rst = 1'b1;
      #1;
      m_reset();
      chk({tag, ".async_gnt"}, 32'(bus_if.gnt), 32'h0);
      chk({tag, ".async_idx"}, 32'(bus_if.gnt_idx), 32'd3);
      chk({tag, ".async_busy"}, 32'(bus_if.busy), 32'd0);
      chk({tag, ".async_to"}, 32'(bus_if.timeout), 32'd0);
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      check_all({tag, ".held"});
   endtask

   // Runs n cycles, pulsing done when the owner reaches cycle done_at (0 = never).
   task automatic run(input string tag, input int n, input int done_at);
      for (int c = 0; c < n; c++) begin
         bus_if.done = (done_at > 0 && m_owner >= 0 && m_tenure == done_at);
         step(tag);
      end
      bus_if.done = 1'b0;
   endtask

   initial begin
      int seq[$];
      int len;
      bit to_seen;
      logic [3:0] prev;

      bus_if.req  = 4'b0000;
      bus_if.done = 1'b0;
      m_reset();
      repeat (2) @(negedge clk);
      rst = 1'b0;
      check_all("reset");

      // Reset with all requests up, then first grant goes to requester 0.
      bus_if.req = 4'b1111;
      run("warm", 3, 2);
      @(negedge clk);
      pulse_reset("rst1111");
      step("rst_first");
      chk("rst_first_gnt", 32'(bus_if.gnt), 32'h1);

      // Single requester with done in the third grant cycle.
      pulse_reset("single_rst");
      bus_if.req = 4'b0100;
      run("single", 14, 3);

      // Rotation with done every second grant cycle.
      pulse_reset("rot_rst");
      bus_if.req = 4'b1111;
      prev = 4'b0000;
      for (int c = 0; c < 40 && seq.size() < 5; c++) begin
         bus_if.done = (m_owner >= 0 && m_tenure == 2);
         step("rot");
         if (prev == 4'b0000 && bus_if.gnt != 4'b0000) seq.push_back(int'(bus_if.gnt));
         prev = bus_if.gnt;
      end
      bus_if.done = 1'b0;
      chk("rot_count", 32'(seq.size()), 32'd5);
      for (int i = 0; i < seq.size() && i < 5; i++) chk("rot_seq", 32'(seq[i]), 32'(1 << (i % 4)));

      // Timeout: full tenure is exactly MAX_HOLD cycles followed by a pulse.
      pulse_reset("to_rst");
      bus_if.req = 4'b0001;
      len = 0;
      to_seen = 1'b0;
      for (int c = 0; c < 20 && !to_seen; c++) begin
         step("to");
         if (bus_if.gnt == 4'b0001) len++;
         if (bus_if.timeout) to_seen = 1'b1;
      end
      chk("to_seen", 32'(to_seen), 32'd1);
      chk("to_len", 32'(len), 32'(MAX_HOLD));
      run("to_regrant", 10, 0);
      run("to_done", 14, MAX_HOLD);

      // Request drop by owner 2 hands the next grant to 3, not 0.
      pulse_reset("drop_rst");
      bus_if.req = 4'b0010;
      run("drop_a", 3, 1);
      bus_if.req = 4'b1111;
      for (int c = 0; c < 10 && m_owner != 2; c++) step("drop_b");
      bus_if.req = 4'b1011;
      prev = 4'b0000;
      for (int c = 0; c < 10 && prev == 4'b0000; c++) begin
         step("drop_c");
         if (m_owner < 0 || bus_if.gnt != 4'b0100) prev = bus_if.gnt;
      end
      chk("drop_next", 32'(prev), 32'h8);

      // Async reset mid-tenure, then restart with req=0010.
      pulse_reset("mid_rst");
      bus_if.req = 4'b0010;
      step("mid_a");
      chk("mid_gnt", 32'(bus_if.gnt), 32'h2);
      pulse_reset("mid_rst2");
      step("mid_b");
      chk("mid_regrant", 32'(bus_if.gnt), 32'h2);
      chk("mid_no_to", 32'(bus_if.timeout), 32'd0);

      // Random traffic.
      for (int c = 0; c < 3000; c++) begin
         if ($urandom_range(0, 3) == 0) bus_if.req = 4'($urandom_range(0, 15));
         bus_if.done = ($urandom_range(0, 5) == 0);
         step("rand");
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule

// File: doc/rr_arbiter_4.md
Name: rr_arbiter_4

Overview:
- Four-requester round-robin arbiter that shares a single downstream resource.
- Produces a registered 2-bit owner index and its one-hot decode: index 0→0001, 1→0010, 2→0100, 3→1000.
- Tracks ownership with a small FSM.
- Bounds each tenure with a hold counter so no requester can starve the others.

Parameters:
- MAX_HOLD, 15: maximum grant tenure in cycles. Legal range is 1 ≤ MAX_HOLD ≤ 2^HOLD_W.
- HOLD_W, 4: width of the internal hold counter.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- req  input  4  request vector; req[i] = requester i wants the resource. Level-sensitive.
- done  input  1  current owner finished; single-cycle pulse, only honoured in GRANT.
- gnt  output  4  registered one-hot grant. All zero when no owner.
- gnt_idx  output  2  registered binary index of the owner. Holds the last owner when gnt = 0.
- busy  output  1  high while in GRANT state.
- timeout  output  1  one-cycle pulse when a tenure ends by hold-limit expiry.

Behaviour:
- Reset (asynchronous, takes effect immediately):
  - state=IDLE, gnt=0000, gnt_idx=3, busy=0, timeout=0, hold_cnt=0.
  - last pointer = 3, so requester 0 has top priority after reset.
- FSM states are IDLE, GRANT and RELEASE. All outputs are registered.
- IDLE:
  - If req==0000, stay in IDLE.
  - Otherwise, at the clock edge the winner becomes owner. Winner = first i with req[i]=1, searching from (last+1) mod 4 upward with wrap-around.
  - On that edge: next state GRANT, gnt_idx=winner, gnt=decode(winner), busy=1, hold_cnt=0.
  - Latency: req sampled at edge N, gnt visible after edge N (one cycle).
- GRANT:
  - hold_cnt increments by 1 each cycle.
  - Release condition, evaluated each edge: done=1, OR req[gnt_idx]=0, OR hold_cnt==MAX_HOLD-1.
  - If the condition is true, at that edge: next state RELEASE, gnt=0000, busy=0, last=gnt_idx.
  - timeout=1 for exactly one cycle only if the hold limit was the sole cause. If done or a request drop coincides with expiry, timeout stays 0.
  - A full-length tenure therefore shows gnt high for exactly MAX_HOLD cycles.
  - Changes on req bits other than the owner's are ignored while in GRANT.
- RELEASE:
  - One mandatory dead cycle with gnt=0000; timeout returns to 0.
  - Next state is IDLE unconditionally.
  - The next grant can appear two cycles after the release edge at the earliest.
- Fairness:
  - The previous owner has the lowest priority in the next arbitration.
  - With all four requests held high, grants rotate 0,1,2,3,0,…
- done outside GRANT is ignored.
- hold_cnt never wraps; it is cleared on every entry to GRANT.
- Reset asserted mid-GRANT clears gnt asynchronously with no RELEASE cycle and no timeout pulse. After reset deassertion, arbitration restarts from last=3.
- Invariant: gnt is zero or one-hot, never multi-hot, and equals decode(gnt_idx) whenever busy=1.

Test Plan:
- Reset check: assert rst mid-simulation with req=1111 → gnt=0000, gnt_idx=3, busy=0, timeout=0 immediately, without waiting for a clock edge. After release with req=1111, the first grant is gnt=0001.
- Single requester: req=0100 held, done pulsed in the 3rd GRANT cycle → gnt=0100 for 3 cycles, one cycle of 0000, then gnt=0100 again. timeout stays 0.
- Round-robin rotation: req=1111, done pulsed every 2nd GRANT cycle → gnt sequence 0001, 0010, 0100, 1000, 0001, each followed by one dead cycle.
- Timeout (MAX_HOLD=4): req=0001 held, no done → gnt=0001 for exactly 4 cycles, timeout=1 on the first dead cycle, then re-grant to 0001. With done pulsed on the 4th cycle, timeout stays 0.
- Request drop: owner 2 deasserts req[2] in its 2nd cycle while req=1011 → next grant goes to 3 (gnt=1000), not 0.
- Async reset mid-tenure: rst pulsed between edges while gnt=0010 → gnt=0000 at once. After rst deasserts with req=0010, gnt=0010 one cycle later, and timeout never pulses.
